multi_packet_sender: RTL and testbench

//  N-channel generalisation of the two-source packet sender: round-robin arbitrates NUM_CH

---
 rtl/multi_packet_sender_pkg.sv | 11 +
 rtl/multi_packet_sender_rr_arbiter.sv | 30 +++
 rtl/multi_packet_sender.sv | 126 ++++++++++++
 tb/tb_multi_packet_sender.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_packet_sender_pkg.sv
// multi_packet_sender_pkg: shared definitions for the multi-channel packet sender
//   FLAG_SOF/FLAG_EOF/FLAG_OCC : bit positions inside the 4-bit f36 flag field
//   HDR_MAGIC                  : top byte of the optional packet header word
//   state_t                    : sender FSM encoding (IDLE/HDR/DATA)
package multi_packet_sender_pkg;
    localparam int FLAG_SOF = 0;
    localparam int FLAG_EOF = 1;
    localparam int FLAG_OCC = 2;
    localparam logic [7:0] HDR_MAGIC = 8'hA5;
    typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;
endpackage

// File: rtl/multi_packet_sender_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first requester at/after ptr
//   req   in  NUM_CH  request per channel
//   ptr   in  4       channel with highest priority this round
//   grant out NUM_CH  one-hot grant (all zero when no request)
//   idx   out 4       index of the granted channel
module rr_arbiter
    import multi_packet_sender_pkg::*;
#(
    parameter int NUM_CH = 4
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [3:0]        ptr,
    output logic [NUM_CH-1:0] grant,
    output logic [3:0]        idx
);
    logic [NUM_CH-1:0] rot;
    logic [3:0]        off;
    logic [4:0]        sum;

    // Rotate the request vector so ptr lands on bit 0, take the lowest set
    // bit, then rotate the offset back into an absolute channel index.
    always_comb begin
        rot = NUM_CH'({req, req} >> ptr);
        off = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) off = rot[i] ? 4'(i) : off;
        sum = {1'b0, ptr} + {1'b0, off};
        idx = (sum >= 5'(NUM_CH)) ? 4'(sum - 5'(NUM_CH)) : sum[3:0];
        grant = (|req) ? (NUM_CH'(1) << idx) : '0;
    end
endmodule

// File: rtl/multi_packet_sender.sv
// multi_packet_sender: round-robin streams whole packets from NUM_CH FWFT FIFOs onto a f36 TX port
//   clk, reset         clock, asynchronous active-high reset
//   ch_fifo_d          FWFT data, channel k at [k*DW +: DW]
//   ch_packet_size_i   packet length in words, channel k at [k*LEN_W +: LEN_W]
//   ch_fifo_req        channel k holds at least one full packet
//   ch_fifo_rd         pop strobe, only ever for the granted channel
//   wr_flags_o         [0]=SOF [1]=EOF [3:2]=occupancy (0)
//   wr_data_o          word to the MAC TX FIFO
//   wr_src_rdy_o       word valid
//   wr_dst_rdy_i       MAC accepts word
//   active_ch_o        granted channel (holds last value when idle)
//   busy_o             packet in progress
// Optional: define MULTI_PACKET_SENDER_HEADER_EN to prefix each packet with a
// {A5, 0, ch, seq} header word carrying SOF and a per-channel sequence number.
module multi_packet_sender
    import multi_packet_sender_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DW     = 32,
    parameter int LEN_W  = 10
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CH*DW-1:0]    ch_fifo_d,
    input  logic [NUM_CH*LEN_W-1:0] ch_packet_size_i,
    input  logic [NUM_CH-1:0]       ch_fifo_req,
    output logic [NUM_CH-1:0]       ch_fifo_rd,
    output logic [3:0]              wr_flags_o,
    output logic [DW-1:0]           wr_data_o,
    output logic                    wr_src_rdy_o,
    input  logic                    wr_dst_rdy_i,
    output logic [3:0]              active_ch_o,
    output logic                    busy_o
);
`ifdef MULTI_PACKET_SENDER_HEADER_EN
    localparam state_t START    = HDR;
    localparam bit     DATA_SOF = 1'b0;
`else
    localparam state_t START    = DATA;
    localparam bit     DATA_SOF = 1'b1;
`endif

    state_t            state, nxt;
    logic [3:0]        ptr, idx;
    logic [NUM_CH-1:0] grant;
    logic [LEN_W-1:0]  size_w, size_q, cnt;
    logic              last, xfer;

    rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .req   (ch_fifo_req),
        .ptr   (ptr),
        .grant (grant),
        .idx   (idx)
    );

    assign size_w = ch_packet_size_i[idx*LEN_W +: LEN_W];
    assign busy_o = state != IDLE;

`ifdef MULTI_PACKET_SENDER_HEADER_EN
    // Indexed directly by the 4-bit channel number, so sized for the 16-channel maximum.
    logic [15:0] seq [16];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) seq[i] <= '0;
        end else if (xfer && last) begin
            seq[active_ch_o] <= seq[active_ch_o] + 16'd1;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            ptr         <= '0;
            active_ch_o <= '0;
            size_q      <= '0;
            cnt         <= '0;
        end else begin
            state <= nxt;
            // A zero-size winner still consumes its turn: the pointer moves on
            // while the FSM stays in IDLE.
            if (state == IDLE && |grant) begin
                active_ch_o <= idx;
                size_q      <= size_w;
                cnt         <= '0;
                ptr         <= (idx == 4'(NUM_CH - 1)) ? 4'd0 : idx + 4'd1;
            end else if (xfer) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_comb begin
        nxt                     = state;
        wr_src_rdy_o            = 1'b0;
        wr_flags_o[FLAG_OCC +: 2] = 2'b00;
        wr_flags_o[FLAG_EOF]    = 1'b0;
        wr_flags_o[FLAG_SOF]    = 1'b0;
        wr_data_o               = '0;
        ch_fifo_rd              = '0;
        xfer                    = 1'b0;
        last                    = cnt == size_q - 1'b1;
        case (state)
            IDLE: nxt = (|grant && size_w != '0) ? START : IDLE;
`ifdef MULTI_PACKET_SENDER_HEADER_EN
            HDR: begin
                wr_src_rdy_o         = 1'b1;
                wr_flags_o[FLAG_SOF] = 1'b1;
                wr_data_o            = {HDR_MAGIC, 4'h0, active_ch_o, seq[active_ch_o]};
                nxt                  = wr_dst_rdy_i ? DATA : HDR;
            end
`endif
            DATA: begin
                wr_src_rdy_o         = 1'b1;
                xfer                 = wr_dst_rdy_i;
                wr_flags_o[FLAG_SOF] = DATA_SOF && cnt == '0;
                wr_flags_o[FLAG_EOF] = last;
                wr_data_o            = ch_fifo_d[active_ch_o*DW +: DW];
                ch_fifo_rd           = xfer ? (NUM_CH'(1) << active_ch_o) : '0;
                nxt                  = (xfer && last) ? IDLE : DATA;
            end
            default: nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_multi_packet_sender.sv
// tb_multi_packet_sender: scoreboard bench for multi_packet_sender (NUM_CH=4)
module tb_multi_packet_sender;
    localparam int N = 4;
`ifdef MULTI_PACKET_SENDER_HEADER_EN
    localparam bit HDR = 1'b1;
`else
    localparam bit HDR = 1'b0;
`endif

    typedef struct packed {
        logic [3:0]  ch;
        logic        pop;
        logic [3:0]  flags;
        logic [31:0] data;
    } exp_t;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N*32-1:0] ch_fifo_d;
    logic [N*10-1:0] ch_packet_size_i;
    logic [N-1:0]    ch_fifo_req;
    logic [N-1:0]    ch_fifo_rd;
    logic [3:0]      wr_flags_o;
    logic [31:0]     wr_data_o;
    logic            wr_src_rdy_o;
    logic            wr_dst_rdy_i = 1'b1;
    logic [3:0]      active_ch_o;
    logic            busy_o;

    logic [15:0] popcnt [N] = '{default: 16'd0};
    logic [15:0] exp_idx [N] = '{default: 16'd0};
    logic [15:0] seq_model [N] = '{default: 16'd0};
    logic [9:0]  sizes [N] = '{default: 10'd0};
    int          pend [N] = '{default: 0};
    logic [N-1:0] force_req = '0;
    logic [N-1:0] pop_mask = '0;
    logic [N-1:0] eof_mask = '0;
    exp_t        q [$];
    int          checks = 0, errors = 0, nwords = 0, cyc = 0, eof_cyc = 0;
    bit          have_eof = 0, chk_gap = 0, stall_prev = 0;
    logic [3:0]  prev_flags = '0;
    logic [31:0] prev_data = '0;

    multi_packet_sender #(.NUM_CH(N), .DW(32), .LEN_W(10)) dut (
        .clk              (clk),
        .reset            (reset),
        .ch_fifo_d        (ch_fifo_d),
        .ch_packet_size_i (ch_packet_size_i),
        .ch_fifo_req      (ch_fifo_req),
        .ch_fifo_rd       (ch_fifo_rd),
        .wr_flags_o       (wr_flags_o),
        .wr_data_o        (wr_data_o),
        .wr_src_rdy_o     (wr_src_rdy_o),
        .wr_dst_rdy_i     (wr_dst_rdy_i),
        .active_ch_o      (active_ch_o),
        .busy_o           (busy_o)
    );

    always #5 clk = ~clk;

    // Source FIFO models: each channel presents {D0+k, 00, pop count}.
    always_comb begin
        ch_fifo_d        = '0;
        ch_packet_size_i = '0;
        ch_fifo_req      = '0;
        for (int k = 0; k < N; k++) begin
            ch_fifo_d[k*32 +: 32]       = {8'hD0 + 8'(k), 8'h00, popcnt[k]};
            ch_packet_size_i[k*10 +: 10] = sizes[k];
            ch_fifo_req[k]              = pend[k] != 0 || force_req[k];
        end
    end

    // Monitor: sample mid-cycle, compare each accepted word against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (!reset) begin
            if (stall_prev && wr_src_rdy_o) begin
                checks++;
                if ({wr_flags_o, wr_data_o} !== {prev_flags, prev_data}) begin
                    errors++;
                    $display("FAIL stall_hold: got %b/%h, held %b/%h", wr_flags_o, wr_data_o, prev_flags, prev_data);
                end
            end
            stall_prev = wr_src_rdy_o && !wr_dst_rdy_i;
            prev_flags = wr_flags_o;
            prev_data  = wr_data_o;
            if (wr_src_rdy_o && wr_dst_rdy_i) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_word: flags=%b data=%h ch=%0d", wr_flags_o, wr_data_o, active_ch_o);
                end else begin
                    e = q.pop_front();
                    if ({wr_flags_o, wr_data_o, active_ch_o} !== {e.flags, e.data, e.ch} ||
                        ch_fifo_rd !== (e.pop ? (N'(1) << e.ch) : N'(0))) begin
                        errors++;
                        $display("FAIL word: got flags=%b data=%h ch=%0d rd=%b, want flags=%b data=%h ch=%0d pop=%b",
                                 wr_flags_o, wr_data_o, active_ch_o, ch_fifo_rd, e.flags, e.data, e.ch, e.pop);
                    end
                    if (e.flags[1]) eof_mask = N'(1) << e.ch;
                end
                if (chk_gap && have_eof && wr_flags_o[0]) begin
                    checks++;
                    if (cyc - eof_cyc != 2) begin
                        errors++;
                        $display("FAIL eof_sof_gap: got %0d cycles, want 2", cyc - eof_cyc);
                    end
                end
                if (wr_flags_o[1]) begin
                    eof_cyc  = cyc;
                    have_eof = 1;
                end
                pop_mask = ch_fifo_rd;
                nwords++;
            end else if (ch_fifo_rd !== '0) begin
                checks++;
                errors++;
                $display("FAIL rd_without_transfer: rd=%b, want 0", ch_fifo_rd);
            end
        end
    end

    // Transfers seen mid-cycle complete on the following edge.
    always @(posedge clk) begin
        for (int k = 0; k < N; k++) begin
            popcnt[k] = popcnt[k] + 16'(pop_mask[k]);
            if (eof_mask[k]) pend[k] = pend[k] - 1;
        end
        pop_mask = '0;
        eof_mask = '0;
    end

    function automatic bit any_pend();
        for (int k = 0; k < N; k++) if (pend[k] != 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic start(input int k, input int n);
        exp_t e;
        sizes[k] = 10'(n);
        pend[k]  = pend[k] + 1;
        if (n > 0 && HDR) begin
            e.ch = 4'(k); e.pop = 1'b0; e.flags = 4'b0001;
            e.data = {8'hA5, 4'h0, 4'(k), seq_model[k]};
            seq_model[k] = seq_model[k] + 16'd1;
            q.push_back(e);
        end
        for (int i = 0; i < n; i++) begin
            e.ch = 4'(k); e.pop = 1'b1; e.flags = '0;
            e.flags[0] = (i == 0) && !HDR;
            e.flags[1] = (i == n - 1);
            e.data = {8'hD0 + 8'(k), 8'h00, exp_idx[k]};
            exp_idx[k] = exp_idx[k] + 16'd1;
            q.push_back(e);
        end
    endtask

    task automatic wait_done(input string name, input int budget);
        int t = 0;
        while ((q.size() != 0 || any_pend() || busy_o) && t < budget) begin
            @(posedge clk);
            t++;
        end
        checks++;
        if (t >= budget) begin
            errors++;
            $display("FAIL %s_timeout: %0d words left after %0d cycles, want 0", name, q.size(), t);
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        wr_dst_rdy_i = 1'b1;
        force_req = '0;
        q.delete();
        for (int k = 0; k < N; k++) pend[k] = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        stall_prev = 0;
        for (int k = 0; k < N; k++) begin
            exp_idx[k]   = popcnt[k];
            seq_model[k] = '0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({wr_src_rdy_o, wr_flags_o, wr_data_o, ch_fifo_rd, busy_o, active_ch_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: src_rdy=%b flags=%b data=%h rd=%b busy=%b ch=%0d, want all 0",
                     wr_src_rdy_o, wr_flags_o, wr_data_o, ch_fifo_rd, busy_o, active_ch_o);
        end
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({wr_src_rdy_o, busy_o} !== 2'b00) begin
            errors++;
            $display("FAIL idle_no_req: src_rdy=%b busy=%b, want 0 0", wr_src_rdy_o, busy_o);
        end
    endtask

    task automatic test_single_packet();
        logic [15:0] p0;
        reset_dut();
        p0 = popcnt[2];
        start(2, 4);
        wait_done("single", 100);
        checks++;
        if (popcnt[2] - p0 !== 16'd4) begin
            errors++;
            $display("FAIL ch2_pops: got %0d, want 4", popcnt[2] - p0);
        end
    endtask

    task automatic test_round_robin();
        reset_dut();
        have_eof = 0;
        chk_gap  = 1;
        start(0, 3); start(1, 3); start(2, 3); start(3, 3); start(0, 3);
        wait_done("round_robin", 300);
        chk_gap = 0;
    endtask

    task automatic test_size_edges();
        logic [15:0] p3;
        reset_dut();
        start(1, 1);
        start(2, 2);
        wait_done("size1", 100);
        // Pointer now sits at ch3; a zero-size ch3 must yield to ch0.
        p3 = popcnt[3];
        sizes[3] = 10'd0;
        force_req[3] = 1'b1;
        start(0, 2);
        wait_done("size0_skip", 100);
        force_req[3] = 1'b0;
        checks++;
        if (popcnt[3] !== p3) begin
            errors++;
            $display("FAIL size0_pops: got %0d, want %0d", popcnt[3], p3);
        end
    endtask

    task automatic test_backpressure();
        int t = 0;
        reset_dut();
        start(0, 8);
        while (q.size() != 0 && t < 200) begin
            @(posedge clk);
            #1 wr_dst_rdy_i = ~wr_dst_rdy_i;
            t++;
        end
        wr_dst_rdy_i = 1'b1;
        wait_done("backpressure", 100);
    endtask

    task automatic test_reset_abort();
        int t = 0;
        int n0;
        reset_dut();
        n0 = nwords;
        start(2, 8);
        while (nwords - n0 < 2 && t < 100) begin
            @(posedge clk);
            t++;
        end
        checks++;
        if (t >= 100) begin
            errors++;
            $display("FAIL abort_timeout: got %0d words, want 2", nwords - n0);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({wr_src_rdy_o, wr_flags_o, wr_data_o, ch_fifo_rd, busy_o, active_ch_o} !== '0) begin
            errors++;
            $display("FAIL abort_outputs: src_rdy=%b flags=%b data=%h rd=%b busy=%b ch=%0d, want all 0",
                     wr_src_rdy_o, wr_flags_o, wr_data_o, ch_fifo_rd, busy_o, active_ch_o);
        end
        reset_dut();
        // ch0 wins only if the pointer went back to 0; a stale pointer (3) would pick ch3.
        start(0, 2);
        start(3, 2);
        wait_done("after_abort", 100);
    endtask

`ifdef MULTI_PACKET_SENDER_HEADER_EN
    task automatic test_header();
        int n0;
        reset_dut();
        n0 = nwords;
        start(1, 2);
        start(1, 2);
        wait_done("header", 100);
        checks++;
        if (nwords - n0 != 6) begin
            errors++;
            $display("FAIL header_word_count: got %0d, want 6", nwords - n0);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_packet();
        test_round_robin();
        test_size_edges();
        test_backpressure();
        test_reset_abort();
`ifdef MULTI_PACKET_SENDER_HEADER_EN
        test_header();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
